grayscale_stream_ctrl: RTL

Frame-level controller that sequences the RGB565-to-grayscale converter inside the object-tracking video pipeline. It accepts a ready/valid RGB565 pixel stream from the camera/frame-buffer side and issues pixels to the converter, whose fixed 1-cycle latency cannot stall. It buffers converter results in a credit-protected FIFO and emits a ready/valid 12-bit grayscale stream tagged with start-of-frame, end-of-line and end-of-frame markers. One `start` runs exactly one `H_ACTIVE x V_ACTIVE` frame.

---
 rtl/grayscale_stream_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/grayscale_stream_ctrl.sv
// grayscale_stream_ctrl
// Frame-level sequencer for the RGB565-to-grayscale converter. Accepts a
// ready/valid RGB565 stream, issues pixels to a fixed 1-cycle-latency
// converter, buffers results in a credit-protected FIFO and emits a tagged
// ready/valid 12-bit grayscale stream. One start runs one H_ACTIVE x V_ACTIVE frame.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 begins one frame (honoured only in IDLE)
//   busy, done, overflow  status: RUN/DRAIN, end-of-frame pulse, sticky FIFO overrun
//   s_pixel/s_valid/s_ready           RGB565 input stream
//   conv_red/green/blue, conv_valid   converter inputs
//   conv_aresetn                      converter reset (active-low)
//   conv_gray, conv_valid_out         converter results
//   m_gray, m_sof/m_eol/m_eof, m_valid/m_ready   tagged grayscale output stream
module grayscale_stream_ctrl #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  input  logic [15:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [4:0]  conv_red,
  output logic [5:0]  conv_green,
  output logic [4:0]  conv_blue,
  output logic        conv_valid,
  output logic        conv_aresetn,
  input  logic [11:0] conv_gray,
  input  logic        conv_valid_out,
  output logic [11:0] m_gray,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          inflight;
  logic          tag_sof_d, tag_eol_d, tag_eof_d;
  logic          at_sof, at_eol, at_eof;
  logic          issue;

  logic [14:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          full, push, pop;
  logic [14:0]   head;

  assign conv_red     = s_pixel[15:11];
  assign conv_green   = s_pixel[10:5];
  assign conv_blue    = s_pixel[4:0];
  assign conv_aresetn = ~reset;

  assign at_sof = (x == '0) && (y == '0);
  assign at_eol = (x == X_LAST);
  assign at_eof = at_eol && (y == Y_LAST);

  // Credit covers both buffered entries and the one result that may still be
  // inside the converter. Gated by reset so no pixel is issued in the reset cycle.
  assign s_ready    = (state == RUN) && !reset && ((count + CW'(inflight)) < DEPTH_C);
  assign issue      = s_valid && s_ready;
  assign conv_valid = issue;

  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign full    = (count == DEPTH_C);
  assign push    = conv_valid_out && (!full || pop);

  assign count_next = count + CW'(push) - CW'(pop);

  assign head   = mem[rd_ptr];
  assign m_gray = m_valid ? head[14:3] : '0;
  assign m_sof  = m_valid && head[2];
  assign m_eol  = m_valid && head[1];
  assign m_eof  = m_valid && head[0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (issue && at_eof) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Uses the post-pop count so done follows the last pop directly.
        if (!inflight && !conv_valid_out && (count_next == '0)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel position and issue-time tags; tags are delayed one cycle so they
  // line up with the converter result they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      inflight  <= 1'b0;
      tag_sof_d <= 1'b0;
      tag_eol_d <= 1'b0;
      tag_eof_d <= 1'b0;
    end else begin
      inflight  <= issue;
      tag_sof_d <= at_sof;
      tag_eol_d <= at_eol;
      tag_eof_d <= at_eof;
      if ((state == IDLE) && start) begin
        x <= '0;
        y <= '0;
      end else if (issue) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y != Y_LAST) y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (conv_valid_out && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {conv_gray, tag_sof_d, tag_eol_d, tag_eof_d};
  end

endmodule
